// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the sprite (OAM) DMA engine.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

  localparam logic [15:0] C_DMA_REG = 16'h4014;
  localparam logic [2:0]  C_OAM_REG = 3'd4;
  localparam int          C_DMA_LEN = 256;

  localparam logic [7:0]  C_LAST_INDEX = 8'(C_DMA_LEN - 1);

  // The CPU is held off the bus in every state except IDLE.
  function automatic logic owns_bus(input oam_dma_state_t state);
    return state != IDLE;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to $4014 copies page $XX00-$XXFF into PPU OAMDATA.
// Optional build macro OAM_DMA_ABORT_EN adds an I_abort input.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] P_dma_reg = C_DMA_REG,
  parameter logic [2:0]  P_oam_reg = C_OAM_REG
) (
  input  logic        I_clock,
  input  logic        I_reset,
`ifdef OAM_DMA_ABORT_EN
  input  logic        I_abort,
`endif
  input  logic        I_tick,
  input  logic [15:0] I_host_addr,
  input  logic        I_host_wren,
  input  logic [7:0]  I_host_data,
  output logic        O_cpu_halt,
  output logic [15:0] O_dma_addr,
  output logic        O_dma_rden,
  input  logic [7:0]  I_dma_data,
  output logic [2:0]  O_ppu_addr,
  output logic        O_ppu_wren,
  output logic [7:0]  O_ppu_data,
  output logic        O_busy
);

  oam_dma_state_t R_state;
  oam_dma_state_t w_state_next;

  logic [7:0] R_page;
  logic [7:0] R_index;
  logic [7:0] R_byte;
  logic       R_odd;

  logic       w_trigger;
  logic       w_last;

  assign w_trigger = I_tick & I_host_wren & (I_host_addr == P_dma_reg);
  assign w_last    = (R_index == C_LAST_INDEX);

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_next and no latch is inferred.
    w_state_next = R_state;
    if (I_tick) begin
      case (R_state)
        IDLE:    if (w_trigger) w_state_next = HALT;
        // Reads must land on even (get) cycles; insert ALIGN if the next cycle is odd.
        HALT:    w_state_next = R_odd ? READ : ALIGN;
        ALIGN:   w_state_next = READ;
        READ:    w_state_next = WRITE;
        WRITE:   w_state_next = w_last ? IDLE : READ;
        default: w_state_next = IDLE;
      endcase
`ifdef OAM_DMA_ABORT_EN
      // In WRITE the byte is already on the PPU port this cycle, so it completes.
      if (I_abort && (R_state != IDLE)) w_state_next = IDLE;
`endif
    end
  end

  always_ff @(posedge I_clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (I_reset) R_state <= IDLE;
    else         R_state <= w_state_next;
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      R_page  <= 8'h00;
      R_index <= 8'h00;
      R_byte  <= 8'h00;
      R_odd   <= 1'b0;
    end else if (I_tick) begin
      R_odd <= ~R_odd;
      if ((R_state == IDLE) && w_trigger) begin
        R_page  <= I_host_data;
        R_index <= 8'h00;
      end
      if (R_state == READ)  R_byte  <= I_dma_data;
      // 8-bit wrap keeps the index from ever carrying into the page.
      if (R_state == WRITE) R_index <= R_index + 8'd1;
    end
  end

  always_comb begin
    O_cpu_halt = owns_bus(R_state);
    O_busy     = owns_bus(R_state);
    O_dma_rden = 1'b0;
    O_dma_addr = 16'h0000;
    O_ppu_wren = 1'b0;
    O_ppu_data = 8'h00;
    O_ppu_addr = P_oam_reg;
    if (R_state == READ) begin
      O_dma_rden = 1'b1;
      O_dma_addr = {R_page, R_index};
    end
    // Strobe drops during every READ, giving the PPU one rising edge per byte.
    if (R_state == WRITE) begin
      O_ppu_wren = 1'b1;
      O_ppu_data = R_byte;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma; one CPU cycle = two clocks (tick, then hold).
// Define OAM_DMA_ABORT_EN to also exercise the abort input.
module tb_oam_dma;
  import oam_dma_pkg::*;

  logic        I_clock = 1'b0;
  logic        I_reset = 1'b1;
`ifdef OAM_DMA_ABORT_EN
  logic        I_abort = 1'b0;
`endif
  logic        I_tick = 1'b0;
  logic [15:0] I_host_addr = 16'h0000;
  logic        I_host_wren = 1'b0;
  logic [7:0]  I_host_data = 8'h00;
  logic        O_cpu_halt;
  logic [15:0] O_dma_addr;
  logic        O_dma_rden;
  logic [7:0]  I_dma_data = 8'h00;
  logic [2:0]  O_ppu_addr;
  logic        O_ppu_wren;
  logic [7:0]  O_ppu_data;
  logic        O_busy;

  oam_dma dut (
    .I_clock    (I_clock),
    .I_reset    (I_reset),
`ifdef OAM_DMA_ABORT_EN
    .I_abort    (I_abort),
`endif
    .I_tick     (I_tick),
    .I_host_addr(I_host_addr),
    .I_host_wren(I_host_wren),
    .I_host_data(I_host_data),
    .O_cpu_halt (O_cpu_halt),
    .O_dma_addr (O_dma_addr),
    .O_dma_rden (O_dma_rden),
    .I_dma_data (I_dma_data),
    .O_ppu_addr (O_ppu_addr),
    .O_ppu_wren (O_ppu_wren),
    .O_ppu_data (O_ppu_data),
    .O_busy     (O_busy)
  );

  always #5 I_clock = ~I_clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          parity = 0;
  int          rd_count, wr_count, halted, mem_mode;
  logic [7:0]  exp_page;
  logic        prev_wren, post_halt, last_was_write, abort_fired, saw_zero;
  logic [15:0] last_rd_addr;
  logic [7:0]  last_wr_data;
  logic [30:0] post_snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (mem_mode == 1) return a[7:0] ^ 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [30:0] snap();
    return {O_cpu_halt, O_busy, O_dma_rden, O_dma_addr, O_ppu_wren, O_ppu_addr, O_ppu_data};
  endfunction

  // Entered and left at a negedge with I_tick low.
  task automatic cpu_cycle(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                           input int abort_at);
    last_was_write = O_ppu_wren;
    abort_fired    = 1'b0;
    if (O_cpu_halt) halted++;
    check("busy_eq_halt", 32'(O_busy), 32'(O_cpu_halt));
    if (O_dma_rden) begin
      check("rd_addr", 32'(O_dma_addr), 32'({exp_page, 8'(rd_count)}));
      check("rd_excl_wr", 32'(O_ppu_wren), 32'(0));
      last_rd_addr = O_dma_addr;
      if (O_dma_addr == 16'h0000) saw_zero = 1'b1;
`ifdef OAM_DMA_ABORT_EN
      if (rd_count == abort_at) begin
        I_abort     = 1'b1;
        abort_fired = 1'b1;
      end
`endif
      rd_count++;
    end
    if (O_ppu_wren) begin
      check("wr_addr", 32'(O_ppu_addr), 32'(3'd4));
      check("wr_data", 32'(O_ppu_data), 32'(mem_byte({exp_page, 8'(wr_count)})));
      check("wr_gap", 32'(prev_wren), 32'(0));
      last_wr_data = O_ppu_data;
      wr_count++;
    end
    prev_wren   = O_ppu_wren;
    I_dma_data  = mem_byte(O_dma_addr);
    I_host_wren = wr;
    I_host_addr = addr;
    I_host_data = data;
    I_tick      = 1'b1;
    @(posedge I_clock);
    @(negedge I_clock);
    I_tick      = 1'b0;
    I_host_wren = 1'b0;
`ifdef OAM_DMA_ABORT_EN
    I_abort     = 1'b0;
`endif
    parity      = parity ^ 1;
    post_halt   = O_cpu_halt;
    post_snap   = snap();
    @(posedge I_clock);
    @(negedge I_clock);
    check("hold_tick_low", 32'(snap()), 32'(post_snap));
  endtask

  task automatic to_parity(input int p);
    if (parity != p) cpu_cycle(1'b0, 16'h0000, 8'h00, -1);
  endtask

  // Trigger a transfer and follow it until the halt releases (or stop_at writes seen).
  task automatic run_dma(input logic [7:0] page, input int inj_at, input int stop_at,
                         input int abort_at, input int exp_halted);
    logic done;
    rd_count = 0; wr_count = 0; halted = 0;
    exp_page = page; saw_zero = 1'b0; prev_wren = 1'b0; done = 1'b0;
    cpu_cycle(1'b1, C_DMA_REG, page, -1);
    check("halt_rise", 32'(post_halt), 32'(1));
    for (int n = 0; n < 600 && !done; n++) begin
      cpu_cycle(n == inj_at, C_DMA_REG, 8'h03, abort_at);
      if (!post_halt) done = 1'b1;
      if (stop_at > 0 && wr_count == stop_at) return;
    end
    check("finished", 32'(done), 32'(1));
    if (abort_at >= 0) begin
      check("abort_writes", 32'(wr_count), 32'(abort_at));
      check("abort_release", 32'(abort_fired), 32'(1));
    end else begin
      check("halted_ticks", 32'(halted), 32'(exp_halted));
      check("read_count", 32'(rd_count), 32'(256));
      check("write_count", 32'(wr_count), 32'(256));
      check("halt_fall_after_last_write", 32'(last_was_write), 32'(1));
    end
  endtask

  initial begin
    mem_mode = 0;
    repeat (3) @(negedge I_clock);
    check("rst_halt", 32'(O_cpu_halt), 32'(0));
    check("rst_busy", 32'(O_busy), 32'(0));
    check("rst_rden", 32'(O_dma_rden), 32'(0));
    check("rst_dma_addr", 32'(O_dma_addr), 32'(0));
    check("rst_wren", 32'(O_ppu_wren), 32'(0));
    check("rst_ppu_data", 32'(O_ppu_data), 32'(0));
    check("rst_ppu_addr", 32'(O_ppu_addr), 32'(3'd4));
    I_reset = 1'b0;
    parity  = 0;

    // $4014 write without a tick must not start a transfer.
    I_host_wren = 1'b1; I_host_addr = C_DMA_REG; I_host_data = 8'h02;
    @(posedge I_clock);
    @(negedge I_clock);
    I_host_wren = 1'b0;
    check("no_trig_tick_low", 32'(O_busy), 32'(0));

    cpu_cycle(1'b1, 16'h4015, 8'h02, -1);
    check("no_trig_wrong_addr", 32'(post_halt), 32'(0));

    to_parity(0);
    run_dma(8'h02, -1, 0, -1, 513);

    to_parity(1);
    run_dma(8'h02, -1, 0, -1, 514);

    mem_mode = 1;
    to_parity(0);
    run_dma(8'hFF, -1, 0, -1, 513);
    check("ff_last_addr", 32'(last_rd_addr), 32'(16'hFFFF));
    check("ff_last_data", 32'(last_wr_data), 32'(8'hA5));
    check("ff_no_zero_addr", 32'(saw_zero), 32'(0));
    mem_mode = 0;

    to_parity(0);
    run_dma(8'h02, 100, 0, -1, 513);

    to_parity(0);
    run_dma(8'h05, -1, 10, -1, 0);
    check("pre_reset_busy", 32'(O_busy), 32'(1));
    I_reset = 1'b1;
    @(posedge I_clock);
    @(negedge I_clock);
    I_reset = 1'b0;
    parity  = 0;
    check("midrst_halt", 32'(O_cpu_halt), 32'(0));
    check("midrst_busy", 32'(O_busy), 32'(0));
    check("midrst_wren", 32'(O_ppu_wren), 32'(0));
    check("midrst_rden", 32'(O_dma_rden), 32'(0));
    repeat (4) cpu_cycle(1'b0, 16'h0000, 8'h00, -1);
    check("midrst_no_more_writes", 32'(wr_count), 32'(10));
    run_dma(8'h04, -1, 0, -1, 513);

`ifdef OAM_DMA_ABORT_EN
    to_parity(0);
    run_dma(8'h06, -1, 0, 5, 0);
    check("abort_idle", 32'(O_busy), 32'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
